// File: rtl/input_debounce_latch_pkg.sv
// Shared constants and FSM encoding for the push-button debounce / switch latch.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package input_debounce_latch_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int SYNC_STAGES_DEF     = 2;
  localparam int CNT_W               = 16;
  localparam int SW_W                = 4;
  localparam int DATA_W              = 32;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  // Stability counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/input_debounce_latch_if.sv
// Board/CPU-side signal bundle of the debounce latch.
// Latency: n/a (wiring only).
// Backpressure: in_ack is the consumer's acknowledge; a press arriving while data is pending is dropped and flagged.
// Ports: botao_n (raw button, active-low), dados_raw (raw switches), in_ack (CPU consume pulse),
//        dado_out (latched value), dado_valido (unconsumed data), botao_pulso (press pulse), overrun (lost press).
interface input_debounce_latch_if;
  import input_debounce_latch_pkg::*;

  logic              botao_n;
  logic [SW_W-1:0]   dados_raw;
  logic              in_ack;
  logic [DATA_W-1:0] dado_out;
  logic              dado_valido;
  logic              botao_pulso;
  logic              overrun;

  // Board and CPU side.
  modport master (
    output botao_n, dados_raw, in_ack,
    input  dado_out, dado_valido, botao_pulso, overrun
  );

  // The debounce/latch block.
  modport slave (
    input  botao_n, dados_raw, in_ack,
    output dado_out, dado_valido, botao_pulso, overrun
  );

endinterface

// File: rtl/input_debounce_latch_entrada_sync.sv
// Multi-flop synchronizer for asynchronous board inputs, resetting to the input's idle level.
// Latency: STAGES rising edges.
// Backpressure: none.
// Ports: clk, reset (async active-high), d_i (async input), q_o (synchronized output).
module entrada_sync #(
  parameter int                 WIDTH     = 1,
  parameter int                 STAGES    = 2,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= RESET_VAL;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/input_debounce_latch.sv
// Debounces the board push-button and latches the switch value for the CPU on each accepted press.
// Latency: SYNC_STAGES+DEBOUNCE_CYCLES+1 edges from first low sample of botao_n to botao_pulso; data lands one edge later.
// Backpressure: data held until in_ack; a press while data is pending is discarded and sets sticky overrun.
// Ports: clk, reset (async active-high), bus (slave modport: botao_n, dados_raw, in_ack,
//        dado_out, dado_valido, botao_pulso, overrun).
module input_debounce_latch
  import input_debounce_latch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input_debounce_latch_if.slave bus
);

  localparam logic [CNT_W-1:0] DC_VAL = CNT_W'(DEBOUNCE_CYCLES);

  logic            botao_n_s;
  logic [SW_W-1:0] dados_s;
  logic            pressed_s;

  entrada_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_botao (
    .clk   (clk),
    .reset (reset),
    .d_i   (bus.botao_n),
    .q_o   (botao_n_s)
  );

  entrada_sync #(.WIDTH(SW_W), .STAGES(SYNC_STAGES), .RESET_VAL('0)) u_sync_dados (
    .clk   (clk),
    .reset (reset),
    .d_i   (bus.dados_raw),
    .q_o   (dados_s)
  );

  assign pressed_s = ~botao_n_s;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pulse_q, pulse_d;
  logic [DATA_W-1:0] dado_q;
  logic              valid_q;
  logic              overrun_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  // Next state. The counter holds the number of consecutive samples seen at
  // the new level; a transition is confirmed one sample after it reaches DC_VAL.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pressed_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = 16'd1;
        end else begin
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!pressed_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DC_VAL) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_sat_inc(cnt_q);
        end
      end
      PRESSED: begin
        if (!pressed_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = 16'd1;
        end else begin
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (pressed_s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DC_VAL) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_sat_inc(cnt_q);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output: the press pulse is registered so it appears in the cycle after
  // PRESS_WAIT->PRESSED, and only that transition can raise it.
  always_comb begin
    pulse_d = (state_q == PRESS_WAIT) && pressed_s && (cnt_q == DC_VAL);
  end

  // Data latch. An ack in the same cycle as a press frees the slot, so the
  // new value is taken and valid stays set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dado_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (pulse_q) begin
      if (!valid_q || bus.in_ack) begin
        dado_q  <= {{(DATA_W-SW_W){1'b0}}, dados_s};
        valid_q <= 1'b1;
      end else begin
        overrun_q <= 1'b1;
      end
    end else if (bus.in_ack) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.dado_out    = dado_q;
  assign bus.dado_valido = valid_q;
  assign bus.botao_pulso = pulse_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_input_debounce_latch.sv
// Directed table-driven bench for input_debounce_latch with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Latency: press pulse expected 7 edges after the first low sample, data one edge later.
// Backpressure: in_ack / overrun behaviour exercised through the vector table.
module tb_input_debounce_latch;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  input_debounce_latch_if bus ();

  input_debounce_latch #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        bn;
    logic [3:0]  d;
    logic        ack;
    int          cyc;
    logic        pulso;
    int          pulses;
    logic        valido;
    logic [31:0] dado;
    logic        ovr;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic bn, input logic [3:0] d, input logic ack, input int cyc,
                     input logic pulso, input int pulses, input logic valido,
                     input logic [31:0] dado, input logic ovr, input string name);
    vec_t v;
    v.bn = bn; v.d = d; v.ack = ack; v.cyc = cyc; v.pulso = pulso; v.pulses = pulses;
    v.valido = valido; v.dado = dado; v.ovr = ovr; v.name = name;
    vecs.push_back(v);
  endtask

  // One rising edge, then settle to the falling edge for sampling.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_outs(input string name, input logic pulso, input logic valido,
                            input logic [31:0] dado, input logic ovr);
    chk({name, ".pulso"},  bus.botao_pulso, pulso);
    chk({name, ".valido"}, bus.dado_valido, valido);
    chk({name, ".dado"},   bus.dado_out,    dado);
    chk({name, ".ovr"},    bus.overrun,     ovr);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;

    // Single accepted press with the button held, then release and ack.
    add(0, 4'h9, 0,  6, 0, 0, 0, 32'h0, 0, "p9_pre");
    add(0, 4'h9, 0,  1, 1, 1, 0, 32'h0, 0, "p9_edge7");
    add(0, 4'h9, 0,  1, 0, 0, 1, 32'h9, 0, "p9_load");
    add(0, 4'h9, 0, 20, 0, 0, 1, 32'h9, 0, "p9_hold");
    add(1, 4'h9, 0, 12, 0, 0, 1, 32'h9, 0, "p9_rel");
    add(1, 4'h9, 1,  1, 0, 0, 0, 32'h9, 0, "ack9");
    add(1, 4'h9, 1,  1, 0, 0, 0, 32'h9, 0, "ack_idle");
    // Bouncing: 3 low / 2 high, five times.
    for (int i = 0; i < 5; i++) begin
      add(0, 4'h6, 0, 3, 0, 0, 0, 32'h9, 0, "bounce_lo");
      add(1, 4'h6, 0, 2, 0, 0, 0, 32'h9, 0, "bounce_hi");
    end
    add(1, 4'h6, 0,  6, 0, 0, 0, 32'h9, 0, "bounce_end");
    // Press, ack, press.
    add(0, 4'h3, 0,  8, 0, 1, 1, 32'h3, 0, "p3");
    add(1, 4'h3, 0, 12, 0, 0, 1, 32'h3, 0, "p3_rel");
    add(1, 4'h3, 1,  1, 0, 0, 0, 32'h3, 0, "ack3");
    add(0, 4'h5, 0,  8, 0, 1, 1, 32'h5, 0, "p5");
    add(1, 4'h5, 0, 12, 0, 0, 1, 32'h5, 0, "p5_rel");
    // Ack coincident with the pulse of a new press, old data pending.
    add(0, 4'hA, 0,  7, 1, 1, 1, 32'h5, 0, "pA_pulse");
    add(0, 4'hA, 1,  1, 0, 0, 1, 32'hA, 0, "pA_ack");
    add(1, 4'hA, 0, 12, 0, 0, 1, 32'hA, 0, "pA_rel");
    // Overrun: second press without ack.
    add(1, 4'hA, 1,  1, 0, 0, 0, 32'hA, 0, "ackA");
    add(0, 4'h3, 0,  8, 0, 1, 1, 32'h3, 0, "o3");
    add(1, 4'h3, 0, 12, 0, 0, 1, 32'h3, 0, "o3_rel");
    add(0, 4'h7, 0,  8, 0, 1, 1, 32'h3, 1, "o7");
    add(1, 4'h7, 0, 12, 0, 0, 1, 32'h3, 1, "o7_rel");
    add(1, 4'h7, 1,  1, 0, 0, 0, 32'h3, 1, "o_ack");
    add(1, 4'h7, 0,  5, 0, 0, 0, 32'h3, 1, "o_sticky");

    // Reset state.
    reset = 1'b1;
    bus.botao_n = 1'b1;
    bus.dados_raw = 4'h0;
    bus.in_ack = 1'b0;
    step();
    step();
    check_outs("reset", 0, 0, 32'h0, 0);
    reset = 1'b0;
    step();
    step();
    check_outs("post_reset", 0, 0, 32'h0, 0);

    foreach (vecs[k]) begin
      bus.botao_n   = vecs[k].bn;
      bus.dados_raw = vecs[k].d;
      bus.in_ack    = vecs[k].ack;
      pulses = 0;
      for (int c = 0; c < vecs[k].cyc; c++) begin
        step();
        if (bus.botao_pulso === 1'b1) pulses++;
      end
      chk({vecs[k].name, ".pulses"}, 32'(pulses), 32'(vecs[k].pulses));
      check_outs(vecs[k].name, vecs[k].pulso, vecs[k].valido, vecs[k].dado, vecs[k].ovr);
    end
    bus.in_ack = 1'b0;

    // Reset in the middle of a debounce (counter at 2) with the button held.
    bus.botao_n   = 1'b0;
    bus.dados_raw = 4'hC;
    repeat (4) step();
    reset = 1'b1;
    #1;
    check_outs("async_reset", 0, 0, 32'h0, 0);
    step();
    step();
    chk("in_reset.pulso", bus.botao_pulso, 1'b0);
    reset = 1'b0;
    pulses = 0;
    repeat (6) begin
      step();
      if (bus.botao_pulso === 1'b1) pulses++;
    end
    chk("rst_redebounce.early_pulses", 32'(pulses), 32'd0);
    step();
    chk("rst_redebounce.pulso_edge7", bus.botao_pulso, 1'b1);
    step();
    check_outs("rst_redebounce.load", 0, 1, 32'hC, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/input_debounce_latch.md
INPUT_DEBOUNCE_LATCH -- requirements
Module: input_debounce_latch

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronized samples required to accept a press or a release (range 2..65535).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2: flip-flop depth of each input synchronizer (minimum 2).
REQ-003 The block SHALL have port clk, input, 1 bit: system clock, all state on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port botao_n, input, 1 bit: raw board push-button, active-low, asynchronous and bouncing.
REQ-006 The block SHALL have port dados_raw, input, 4 bits: raw board switches, asynchronous.
REQ-007 The block SHALL have port in_ack, input, 1 bit: single-cycle pulse from the CPU when an IN instruction consumes dado_out.
REQ-008 The block SHALL have port dado_out, output, 32 bits: latched switch value, zero-extended.
REQ-009 The block SHALL have port dado_valido, output, 1 bit: dado_out holds unconsumed data.
REQ-010 The block SHALL have port botao_pulso, output, 1 bit: one-cycle pulse per accepted press, drives the CPU pause-release input.
REQ-011 The block SHALL have port overrun, output, 1 bit: sticky flag, a press was lost.

Function
REQ-012 Each of botao_n and dados_raw SHALL pass through its own SYNC_STAGES-deep synchronizer before any other use; the synchronized press is pressed_s = NOT (synchronized botao_n).
REQ-013 The debounce FSM SHALL have exactly the states IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, plus a 16-bit stability counter.
REQ-014 In IDLE, pressed_s=1 SHALL move the FSM to PRESS_WAIT with counter=1; otherwise the FSM SHALL stay in IDLE with counter=0.
REQ-015 In PRESS_WAIT, pressed_s=0 SHALL return the FSM to IDLE with counter=0 (bounce rejected).
REQ-016 In PRESS_WAIT with pressed_s=1 and counter=DEBOUNCE_CYCLES, the FSM SHALL enter PRESSED; otherwise, with pressed_s=1, the counter SHALL increment.
REQ-017 botao_pulso SHALL be 1 for exactly the one cycle following the PRESS_WAIT->PRESSED transition.
REQ-018 Total latency SHALL be SYNC_STAGES+DEBOUNCE_CYCLES+1 rising edges from the first edge sampling botao_n=0 to botao_pulso=1, given a stable input.
REQ-019 In PRESSED, pressed_s=0 SHALL move the FSM to RELEASE_WAIT with counter=1.
REQ-020 In RELEASE_WAIT, pressed_s=1 SHALL return the FSM to PRESSED.
REQ-021 In RELEASE_WAIT, DEBOUNCE_CYCLES consecutive pressed_s=0 samples SHALL return the FSM to IDLE with no output pulse.
REQ-022 Holding the button indefinitely SHALL produce exactly one botao_pulso.
REQ-023 On an accepted press (the botao_pulso cycle) with dado_valido=0, the block SHALL load dado_out with {28'b0, synchronized dados_raw} and set dado_valido=1.
REQ-024 in_ack=1 SHALL clear dado_valido on the next edge and SHALL leave dado_out unchanged.
REQ-025 An accepted press with dado_valido=1 and in_ack=0 SHALL discard the new value, keep dado_out, and set overrun=1.
REQ-026 An accepted press coincident with in_ack=1 SHALL load the new value, keep dado_valido=1, and leave overrun unchanged.
REQ-027 in_ack with dado_valido=0 SHALL have no effect.
REQ-028 overrun SHALL clear only on reset.
REQ-029 The debounce counter SHALL saturate and never wrap.

Reset
REQ-030 While reset=1, the block SHALL immediately force FSM=IDLE, counter=0, all synchronizer stages to the idle level (botao_n=1, dados=0), dado_out=0, dado_valido=0, botao_pulso=0 and overrun=0.
REQ-031 A reset asserted mid-debounce or mid-pulse SHALL abort the operation with no pulse; after release, a still-held button SHALL require a full new debounce before it is accepted.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (2-bit: IDLE=0, PRESS_WAIT=1, PRESSED=2, RELEASE_WAIT=3) and the DEBOUNCE_CYCLES and SYNC_STAGES default constants.
REQ-033 The parameterized synchronizer SHALL be one sub-module, entrada_sync, instantiated for botao_n (width 1) and for dados_raw (width 4).

Verification
REQ-034 DEBOUNCE_CYCLES=4: botao_n held low, dados_raw=4'h9 -> exactly one botao_pulso at edge 7 after first low sample; dado_out=32'h9; dado_valido=1.
REQ-035 DEBOUNCE_CYCLES=4: botao_n low for 3 cycles, high for 2, repeated 5 times -> no botao_pulso; dado_valido remains 0.
REQ-036 Press with dados=4'h3, then in_ack, then press with dados=4'h5 -> dado_out=32'h5; dado_valido=1; overrun=0.
REQ-037 Press 4'h3, then second press 4'h7 with no ack -> dado_out stays 32'h3; overrun=1 until reset.
REQ-038 in_ack asserted on the exact botao_pulso cycle of press 4'hA, with old data pending -> dado_out=32'hA; dado_valido=1; overrun=0.
REQ-039 Reset pulsed at counter=2 while botao_n is held low -> no pulse; after reset, pulse at full latency.
